// File: rtl/morse_letter_decoder.sv
// Morse letter decoder: aligns to the first tone of a letter, samples 12 slots at
// mid-slot and matches the captured pattern against the A-H table.
module morse_letter_decoder #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int SYMBOL_CYCLES   = CLOCK_FREQUENCY / 2
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       DotDashIn,
    output logic [2:0] Letter,
    output logic       LetterValid,
    output logic       LetterError,
    output logic       Busy
);

    localparam int TIMER_W = $clog2(SYMBOL_CYCLES + 1);
    localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(SYMBOL_CYCLES / 2);
    localparam logic [TIMER_W-1:0] FULL_LOAD = TIMER_W'(SYMBOL_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
    localparam logic [3:0]         LAST_SLOT = 4'd11;

    // Entry i is letter i (A=0 ... H=7); bit 11 is the first slot on the line.
    localparam logic [7:0][11:0] PATTERNS = {
        12'b101010100000,  // H
        12'b111011101000,  // G
        12'b101011101000,  // F
        12'b100000000000,  // E
        12'b111010100000,  // D
        12'b111010111010,  // C
        12'b111010101000,  // B
        12'b101110000000   // A
    };

    if (SYMBOL_CYCLES < 2 || CLOCK_FREQUENCY < 1) begin : g_bad_params
        $error("morse_letter_decoder: SYMBOL_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DECIDE
    } state_t;

    state_t             r_state;
    logic               r_prev;
    logic [TIMER_W-1:0] r_timer;
    logic [3:0]         r_slot;
    logic [11:0]        r_capture;
    logic [2:0]         r_letter;
    logic               r_valid;
    logic               r_error;

    state_t             w_state_next;
    logic [TIMER_W-1:0] w_timer_next;
    logic [3:0]         w_slot_next;
    logic [11:0]        w_capture_next;
    logic [2:0]         w_letter_next;
    logic               w_valid_next;
    logic               w_error_next;
    logic               w_match;
    logic [2:0]         w_match_idx;

    always_comb begin
        w_match     = 1'b0;
        w_match_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_capture == PATTERNS[i]) begin
                w_match     = 1'b1;
                w_match_idx = 3'(i);
            end
        end
    end

    // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_slot_next    = r_slot;
        w_capture_next = r_capture;
        w_letter_next  = r_letter;
        w_valid_next   = 1'b0;
        w_error_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!r_prev && DotDashIn) begin
                    w_state_next = S_CAPTURE;
                    w_timer_next = HALF_LOAD;
                    w_slot_next  = 4'd0;
                end
            end
            S_CAPTURE: begin
                if (r_timer == TIMER_ONE) begin
                    w_capture_next = {r_capture[10:0], DotDashIn};
                    w_timer_next   = FULL_LOAD;
                    w_slot_next    = r_slot + 4'd1;
                    if (r_slot == LAST_SLOT) begin
                        w_state_next = S_DECIDE;
                    end
                end else begin
                    w_timer_next = r_timer - TIMER_ONE;
                end
            end
            S_DECIDE: begin
                if (w_match) begin
                    w_letter_next = w_match_idx;
                    w_valid_next  = 1'b1;
                end else begin
                    w_error_next  = 1'b1;
                end
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_prev    <= 1'b1;  // a line already high at reset release is not a start
            r_timer   <= '0;
            r_slot    <= '0;
            r_capture <= '0;
            r_letter  <= 3'd0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_prev    <= DotDashIn;
            r_timer   <= w_timer_next;
            r_slot    <= w_slot_next;
            r_capture <= w_capture_next;
            r_letter  <= w_letter_next;
            r_valid   <= w_valid_next;
            r_error   <= w_error_next;
        end
    end

    assign Letter      = r_letter;
    assign LetterValid = r_valid;
    assign LetterError = r_error;
    assign Busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_morse_letter_decoder.sv
// Bench for morse_letter_decoder: two instances (4 and 5 cycles per slot) checked
// every cycle against a slot-timing model, plus literal checks on directed letters.
module tb_morse_letter_decoder;

    logic       clk = 1'b0;
    logic       rst4 = 1'b1, line4 = 1'b0;
    logic       rst5 = 1'b1, line5 = 1'b0;
    logic [2:0] letter4, letter5;
    logic       valid4, valid5, err4, err5, busy4, busy5;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    morse_letter_decoder #(.CLOCK_FREQUENCY(8), .SYMBOL_CYCLES(4)) dut4 (
        .ClockIn(clk), .Reset(rst4), .DotDashIn(line4),
        .Letter(letter4), .LetterValid(valid4), .LetterError(err4), .Busy(busy4)
    );

    morse_letter_decoder #(.CLOCK_FREQUENCY(10), .SYMBOL_CYCLES(5)) dut5 (
        .ClockIn(clk), .Reset(rst5), .DotDashIn(line5),
        .Letter(letter5), .LetterValid(valid5), .LetterError(err5), .Busy(busy5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [11:0] pat_of(input int idx);
        string table_s [8] = '{"101110000000", "111010101000", "111010111010", "111010100000",
                               "100000000000", "101011101000", "111011101000", "101010100000"};
        string s;
        logic [11:0] r;
        s = table_s[idx];
        for (int i = 0; i < 12; i++) r[11 - i] = (s[i] == 8'h31);
        return r;
    endfunction

    // Model: a letter starts at cycle t; sample k lands at t+H+k*S, decision at t+H+11*S+1.
    typedef struct {
        bit          in_letter;
        int          t;
        logic [11:0] pat;
        bit          prev;
        logic [2:0]  letter;
        bit          busy;
        bit          valid;
        bit          err;
    } model_t;

    model_t m [2];

    task automatic model_step(inout model_t s, input int n, input int sc, input logic rst,
                              input logic d);
        int  off;
        bit  found;
        s.valid = 1'b0;
        s.err   = 1'b0;
        if (rst) begin
            s.in_letter = 1'b0;
            s.prev      = 1'b1;
            s.letter    = 3'd0;
            s.busy      = 1'b0;
            return;
        end
        if (s.in_letter) begin
            off = n - s.t - sc / 2;
            if (off >= 0 && off % sc == 0 && off / sc < 12) s.pat[11 - off / sc] = d;
            if (off == 11 * sc + 1) begin
                found = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (s.pat == pat_of(i)) begin
                        found    = 1'b1;
                        s.letter = 3'(i);
                    end
                end
                s.valid     = found;
                s.err       = !found;
                s.in_letter = 1'b0;
                s.busy      = 1'b0;
            end
        end else if (!s.prev && d) begin
            s.in_letter = 1'b1;
            s.t         = n;
            s.pat       = '0;
            s.busy      = 1'b1;
        end
        s.prev = d;
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(m[0], cyc, 4, rst4, line4);
        model_step(m[1], cyc, 5, rst5, line5);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("busy4",   busy4,   m[0].busy);
            check("valid4",  valid4,  m[0].valid);
            check("error4",  err4,    m[0].err);
            check("letter4", letter4, m[0].letter);
            check("busy5",   busy5,   m[1].busy);
            check("valid5",  valid5,  m[1].valid);
            check("error5",  err5,    m[1].err);
            check("letter5", letter5, m[1].letter);
        end
    end

    // Called at a negedge; the line goes high before edge t = cyc+1.
    task automatic send(input int sel, input logic [11:0] pat, input int reset_at, input bit lit,
                        input logic exp_valid, input logic exp_err, input logic [2:0] exp_letter);
        int sc;
        int strobe_c;
        logic d;
        sc       = (sel != 0) ? 5 : 4;
        strobe_c = sc / 2 + 11 * sc + 2;
        for (int c = 0; c <= 12 * sc; c++) begin
            if (lit && c == strobe_c - 1 && reset_at < 0)
                check("lit_busy_before_decide", (sel != 0) ? busy5 : busy4, 1);
            if (lit && c == strobe_c) begin
                check("lit_valid",  (sel != 0) ? valid5 : valid4, exp_valid);
                check("lit_error",  (sel != 0) ? err5 : err4, exp_err);
                check("lit_letter", (sel != 0) ? letter5 : letter4, exp_letter);
                check("lit_busy_after", (sel != 0) ? busy5 : busy4, 0);
            end
            if (lit && reset_at >= 0 && c == reset_at + 1) begin
                check("lit_reset_busy",   (sel != 0) ? busy5 : busy4, 0);
                check("lit_reset_letter", (sel != 0) ? letter5 : letter4, 0);
            end
            if (c == 12 * sc) break;
            d = (reset_at >= 0 && c >= reset_at) ? 1'b0 : pat[11 - c / sc];
            if (sel != 0) begin
                line5 = d;
                rst5  = (c == reset_at);
            end else begin
                line4 = d;
                rst4  = (c == reset_at);
            end
            @(negedge clk);
        end
        if (sel != 0) rst5 = 1'b0;
        else rst4 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [11:0] pat;
        int          gap;
        int          rat;

        check("model_pat_A", pat_of(0), 12'b101110000000);
        check("model_pat_H", pat_of(7), 12'b101010100000);

        repeat (3) @(negedge clk);
        rst4 = 1'b0;
        rst5 = 1'b0;
        check("reset_letter4", letter4, 0);
        check("reset_busy4",   busy4,   0);
        check("reset_valid4",  valid4,  0);
        repeat (3) @(negedge clk);

        send(0, pat_of(0), -1, 1, 1, 0, 3'b000);           // A
        send(0, pat_of(4), -1, 1, 1, 0, 3'b100);           // E
        send(0, pat_of(7), -1, 1, 1, 0, 3'b111);           // H back-to-back
        send(0, pat_of(6), -1, 1, 1, 0, 3'b110);           // G
        send(0, 12'b110000000000, -1, 1, 0, 1, 3'b110);    // invalid
        send(0, pat_of(2), 20, 1, 0, 0, 3'b000);           // C aborted by reset
        repeat (4) @(negedge clk);
        send(0, pat_of(3), -1, 1, 1, 0, 3'b011);           // D

        rst4  = 1'b1;
        line4 = 1'b1;
        repeat (3) @(negedge clk);
        rst4 = 1'b0;
        repeat (10) @(negedge clk);
        check("line_high_busy", busy4, 0);
        line4 = 1'b0;
        repeat (4) @(negedge clk);
        send(0, pat_of(5), -1, 1, 1, 0, 3'b101);           // F

        for (int i = 0; i < 8; i++) send(1, pat_of(i), -1, 1, 1, 0, 3'(i));

        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 3) == 0) pat = {1'b1, 11'($urandom)};
            else pat = pat_of(int'($urandom_range(0, 7)));
            rat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 47)) : -1;
            send(0, pat, rat, 0, 0, 0, 3'b000);
            gap = int'($urandom_range(0, 5));
            line4 = 1'b0;
            repeat (gap) @(negedge clk);
        end

        repeat (300) begin
            line4 = 1'($urandom);
            rst4  = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        rst4  = 1'b0;
        line4 = 1'b0;
        repeat (80) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
